turn_sequencer: RTL and testbench
=================================

Name: turn_sequencer

Overview:
- Owns the 3x3 board register and sequences turns between the human player and the computer.
- Drives pos1..pos9 into the downstream win/block checker, which flags whether a line has two matching marks and an empty third cell.
- Consumes that checker's registered check/blockthis result to place the computer's move. Falls back to a fixed preference order when no line is flagged.
- Detects player win, computer win and draw, and presents game status to the display logic.

Parameters:
- SETTLE_CYCLES, 1: wait cycles between the end of player-move evaluation and the computer placing its mark. Covers the checker's 1-cycle registered latency. Legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high; clears board and state
- restart  input  1  sync pulse; clears board and returns to player turn from any state
- player_move  input  1  1-cycle strobe; player requests a move
- player_pos  input  4  requested cell, 1..9
- check  input  1  from checker: blockthis is valid
- blockthis  input  4  from checker: cell (1..9) to play
- pos1..pos9  output  2 each  cell state: 00 empty, 01 player, 10 computer
- player_turn  output  1  high while in S_PLAYER
- illegal  output  1  1-cycle pulse on a rejected player move
- last_comp_pos  output  4  cell of the most recent computer move; 0 if none yet
- game_over  output  1  high in S_DONE
- winner  output  2  00 none, 01 player, 10 computer, 11 draw

Behaviour:
Reset (async):
- All cells 00; state S_PLAYER; illegal=0, last_comp_pos=0, game_over=0, winner=00, wait counter=0.

restart:
- Same effect as reset, applied synchronously. Takes priority over every other event in that cycle.

All outputs are registered. player_turn is decoded from the state register.

States:
- S_PLAYER:
  - player_move sampled only in this state.
  - Accept when player_pos is 1..9 and that cell is 00: write 01 at the clock edge, go to S_EVALP.
  - Reject otherwise: illegal pulses high for the next cycle, board unchanged, stay in S_PLAYER.
- S_EVALP: combinational line check (8 lines) on the updated board.
  - Three 01 in a line: winner=01, go to S_DONE.
  - Else all cells non-empty: winner=11, go to S_DONE.
  - Else load counter=SETTLE_CYCLES, go to S_WAIT.
  - The checker samples the new board during this cycle.
- S_WAIT: decrement the counter each cycle; go to S_COMP when it reaches 1.
- S_COMP: choose the target cell.
  - If check=1, blockthis is 1..9, and that cell is 00: target=blockthis.
  - Otherwise target is the first empty cell in the order 5,1,3,7,9,2,4,6,8.
  - Write 10 at the target, last_comp_pos=target, go to S_EVALC.
- S_EVALC:
  - Three 10 in a line: winner=10, go to S_DONE.
  - Else board full: winner=11, go to S_DONE.
  - Else go to S_PLAYER.
- S_DONE: game_over=1. Board and winner held. player_move ignored, illegal stays 0. Exit only via restart or reset.

Boundaries:
- player_move outside S_PLAYER is ignored silently (no illegal pulse).
- player_pos=0 or 10..15 is illegal.
- A stale or invalid blockthis (occupied cell, or 0) is ignored; fallback order applies.
- Reset or restart mid-sequence, including in S_WAIT or S_COMP, discards the pending computer move.
- Player's winning move and a full board in the same cycle: player win takes precedence over draw.
- Latency from player_move accept to the computer mark visible on pos*: 3+SETTLE_CYCLES-1 cycles (3 with the default).

Optional Feature:
COMPUTER_FIRST_EN
- Defined:
  - After reset or restart, the state machine enters S_COMP instead of S_PLAYER.
  - check is ignored on this first move, so the computer plays cell 5; last_comp_pos=5.
  - Flow then continues via S_EVALC to S_PLAYER.
- Undefined: the player always moves first, as described above.

Test Plan:
1. Reset, then player_move with pos=1 → pos1=01 next cycle. With check=0 held, pos5=10 three cycles after accept; last_comp_pos=5; player_turn high again.
2. Board player{1,2}, computer{5}; checker returns check=1, blockthis=3 → computer writes pos3=10; winner stays 00.
3. player_move pos=5 while pos5=10 → illegal high exactly 1 cycle, board unchanged. Also player_pos=12 → illegal, board unchanged.
4. Player completes line 3-5-7 → winner=01, game_over=1, no computer move. Further player_move ignored; restart clears all cells and returns to S_PLAYER.
5. Fill the board to 8 cells with no line; player takes the last cell → winner=11 next cycle.
6. Assert reset in S_WAIT (SETTLE_CYCLES=4) → all cells 00 immediately; no computer write. With COMPUTER_FIRST_EN defined, after reset pos5=10 within 2 cycles.

Source files
------------

// File: rtl/turn_sequencer.sv
// turn_sequencer: owns the 3x3 board and alternates player / computer turns.
// Optional COMPUTER_FIRST_EN: after reset or restart the computer opens on cell 5.
module turn_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       player_move,
    input  logic [3:0] player_pos,
    input  logic       check,
    input  logic [3:0] blockthis,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       player_turn,
    output logic       illegal,
    output logic [3:0] last_comp_pos,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [2:0] S_PLAYER = 3'd0;
    localparam logic [2:0] S_EVALP  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_COMP   = 3'd3;
    localparam logic [2:0] S_EVALC  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

`ifdef COMPUTER_FIRST_EN
    localparam logic [2:0] S_START    = S_COMP;
    localparam logic       FIRST_INIT = 1'b1;
`else
    localparam logic [2:0] S_START    = S_PLAYER;
    localparam logic       FIRST_INIT = 1'b0;
`endif

    localparam logic [1:0] EMPTY    = 2'b00;
    localparam logic [1:0] PLAYER   = 2'b01;
    localparam logic [1:0] COMPUTER = 2'b10;

    localparam logic [1:0] W_PLAYER = 2'b01;
    localparam logic [1:0] W_COMP   = 2'b10;
    localparam logic [1:0] W_DRAW   = 2'b11;

    // Fallback preference, entry 0 first: centre, corners, then edges.
    localparam logic [8:0][3:0] FALLBACK = {4'd8, 4'd6, 4'd4, 4'd2, 4'd9,
                                            4'd7, 4'd3, 4'd1, 4'd5};

    logic [2:0]      state_q, state_d;
    logic [8:0][1:0] board_q, board_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      last_q, last_d;
    logic [1:0]      winner_q, winner_d;
    logic            first_q, first_d;

    logic            player_ok;
    logic            block_ok;
    logic [3:0]      target;

    function automatic logic has_line(input logic [8:0][1:0] b, input logic [1:0] m);
        return (b[0] == m && b[1] == m && b[2] == m) ||
               (b[3] == m && b[4] == m && b[5] == m) ||
               (b[6] == m && b[7] == m && b[8] == m) ||
               (b[0] == m && b[3] == m && b[6] == m) ||
               (b[1] == m && b[4] == m && b[7] == m) ||
               (b[2] == m && b[5] == m && b[8] == m) ||
               (b[0] == m && b[4] == m && b[8] == m) ||
               (b[2] == m && b[4] == m && b[6] == m);
    endfunction

    function automatic logic is_full(input logic [8:0][1:0] b);
        logic full;
        full = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (b[c] == EMPTY) full = 1'b0;
        end
        return full;
    endfunction

    // The checker's suggestion is trusted only if it names an empty cell.
    always_comb begin
        player_ok = 1'b0;
        block_ok  = 1'b0;
        target    = 4'd0;
        for (int c = 0; c < 9; c++) begin
            if (player_pos == 4'(c + 1) && board_q[c] == EMPTY) player_ok = 1'b1;
            if (blockthis == 4'(c + 1) && board_q[c] == EMPTY) block_ok = 1'b1;
        end
        for (int i = 8; i >= 0; i--) begin
            if (board_q[FALLBACK[i] - 4'd1] == EMPTY) target = FALLBACK[i];
        end
        if (check && !first_q && block_ok) target = blockthis;
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        last_d    = last_q;
        winner_d  = winner_q;
        first_d   = first_q;
        if (restart) begin
            state_d  = S_START;
            board_d  = '0;
            cnt_d    = 4'd0;
            last_d   = 4'd0;
            winner_d = 2'b00;
            first_d  = FIRST_INIT;
        end else begin
            case (state_q)
                S_PLAYER: begin
                    if (player_move) begin
                        if (player_ok) begin
                            for (int c = 0; c < 9; c++) begin
                                if (player_pos == 4'(c + 1)) board_d[c] = PLAYER;
                            end
                            state_d = S_EVALP;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                S_EVALP: begin
                    if (has_line(board_q, PLAYER)) begin
                        winner_d = W_PLAYER;
                        state_d  = S_DONE;
                    end else if (is_full(board_q)) begin
                        winner_d = W_DRAW;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = 4'(SETTLE_CYCLES);
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = S_COMP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_COMP: begin
                    for (int c = 0; c < 9; c++) begin
                        if (target == 4'(c + 1)) board_d[c] = COMPUTER;
                    end
                    last_d  = target;
                    first_d = 1'b0;
                    state_d = S_EVALC;
                end
                S_EVALC: begin
                    if (has_line(board_q, COMPUTER)) begin
                        winner_d = W_COMP;
                        state_d  = S_DONE;
                    end else if (is_full(board_q)) begin
                        winner_d = W_DRAW;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_PLAYER;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_PLAYER;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_START;
            board_q   <= '0;
            cnt_q     <= 4'd0;
            illegal_q <= 1'b0;
            last_q    <= 4'd0;
            winner_q  <= 2'b00;
            first_q   <= FIRST_INIT;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            last_q    <= last_d;
            winner_q  <= winner_d;
            first_q   <= first_d;
        end
    end

    assign pos1          = board_q[0];
    assign pos2          = board_q[1];
    assign pos3          = board_q[2];
    assign pos4          = board_q[3];
    assign pos5          = board_q[4];
    assign pos6          = board_q[5];
    assign pos7          = board_q[6];
    assign pos8          = board_q[7];
    assign pos9          = board_q[8];
    assign player_turn   = (state_q == S_PLAYER);
    assign game_over     = (state_q == S_DONE);
    assign illegal       = illegal_q;
    assign last_comp_pos = last_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed game scenarios plus random play against a game-level model.
// Honours COMPUTER_FIRST_EN the same way the design does.
module tb_turn_sequencer;

    localparam int SETTLE = 3;

    logic       clk = 1'b0;
    logic       reset, restart, player_move, check;
    logic [3:0] player_pos, blockthis, last_comp_pos;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, winner;
    logic       player_turn, illegal, game_over;
    logic [17:0] dut_board;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    turn_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .player_move(player_move), .player_pos(player_pos),
        .check(check), .blockthis(blockthis),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .player_turn(player_turn), .illegal(illegal),
        .last_comp_pos(last_comp_pos), .game_over(game_over), .winner(winner)
    );

    assign dut_board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

    // Game-level model: cells 1..9 hold 0 empty, 1 player, 2 computer.
    int mb[1:9];
    int m_win, m_last, comp_in;
    bit m_ill, m_turn, m_over, m_first, pend_eval, pend_ceval;
    int lines[8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                        '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
    int order[9] = '{5, 1, 3, 7, 9, 2, 4, 6, 8};

    function automatic void modelInit();
        for (int c = 1; c <= 9; c++) mb[c] = 0;
        m_win = 0; m_last = 0; m_ill = 0; m_over = 0;
        pend_eval = 0; pend_ceval = 0;
`ifdef COMPUTER_FIRST_EN
        m_turn = 0; comp_in = 1; m_first = 1;
`else
        m_turn = 1; comp_in = 0; m_first = 0;
`endif
    endfunction

    function automatic bit modelLine(input int mark);
        for (int l = 0; l < 8; l++) begin
            if (mb[lines[l][0]] == mark && mb[lines[l][1]] == mark && mb[lines[l][2]] == mark)
                return 1;
        end
        return 0;
    endfunction

    function automatic bit modelFull();
        for (int c = 1; c <= 9; c++) if (mb[c] == 0) return 0;
        return 1;
    endfunction

    function automatic void compMove();
        int tgt;
        int bt;
        tgt = 0;
        bt = int'(blockthis);
        if (check && !m_first && bt >= 1 && bt <= 9) begin
            if (mb[bt] == 0) tgt = bt;
        end
        for (int i = 0; i < 9; i++) begin
            if (tgt == 0 && mb[order[i]] == 0) tgt = order[i];
        end
        mb[tgt] = 2;
        m_last = tgt;
        m_first = 0;
    endfunction

    function automatic void modelStep();
        int pp;
        m_ill = 0;
        if (restart) begin
            modelInit();
            return;
        end
        if (pend_eval) begin
            pend_eval = 0;
            if (modelLine(1)) begin m_win = 1; m_over = 1; end
            else if (modelFull()) begin m_win = 3; m_over = 1; end
            else comp_in = SETTLE + 1;
        end else if (comp_in > 0) begin
            comp_in--;
            if (comp_in == 0) begin
                compMove();
                pend_ceval = 1;
            end
        end else if (pend_ceval) begin
            pend_ceval = 0;
            if (modelLine(2)) begin m_win = 2; m_over = 1; end
            else if (modelFull()) begin m_win = 3; m_over = 1; end
            else m_turn = 1;
        end else if (m_turn && player_move) begin
            pp = int'(player_pos);
            m_ill = 1;
            if (pp >= 1 && pp <= 9) begin
                if (mb[pp] == 0) begin
                    mb[pp] = 1;
                    m_turn = 0;
                    m_ill = 0;
                    pend_eval = 1;
                end
            end
        end
    endfunction

    function automatic logic [17:0] modelBoard();
        logic [17:0] b;
        b = '0;
        for (int c = 1; c <= 9; c++) b[2*(c-1) +: 2] = 2'(mb[c]);
        return b;
    endfunction

    // Independent literal board builder: bit (cell-1) of each mask marks that cell.
    function automatic logic [17:0] boardLit(input logic [8:0] pmask, input logic [8:0] cmask);
        logic [17:0] b;
        b = '0;
        for (int c = 0; c < 9; c++) begin
            if (pmask[c]) b[2*c +: 2] = 2'b01;
            if (cmask[c]) b[2*c +: 2] = 2'b10;
        end
        return b;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) modelInit();
        else modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("board", 32'(dut_board), 32'(modelBoard()));
        checkOutput("illegal", 32'(illegal), 32'(m_ill));
        checkOutput("player_turn", 32'(player_turn), 32'(m_turn));
        checkOutput("game_over", 32'(game_over), 32'(m_over));
        checkOutput("winner", 32'(winner), 32'(m_win));
        checkOutput("last_comp_pos", 32'(last_comp_pos), 32'(m_last));
    end

    task automatic applyStimulus(input logic [3:0] pos, input logic chk, input logic [3:0] blk);
        @(negedge clk);
        #1;
        player_move = 1'b1;
        player_pos  = pos;
        check       = chk;
        blockthis   = blk;
        @(negedge clk);
        player_move = 1'b0;
    endtask

    task automatic restartPulse();
        @(negedge clk);
        #1 restart = 1'b1;
        @(negedge clk);
        #1 restart = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(player_turn || game_over) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_wait_in_bound", 32'(n < 50), 32'd1);
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; player_move = 1'b0;
        player_pos = 4'd0; check = 1'b0; blockthis = 4'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_board", 32'(dut_board), 32'd0);
        checkOutput("reset_winner", 32'(winner), 32'd0);
        checkOutput("reset_last", 32'(last_comp_pos), 32'd0);
        #1 reset = 1'b0;

`ifndef COMPUTER_FIRST_EN
        checkOutput("reset_turn", 32'(player_turn), 32'd1);
        // Opening move, computer falls back to centre.
        applyStimulus(4'd1, 1'b0, 4'd0);
        checkOutput("t1_pos1", 32'(pos1), 32'd1);
        repeat (1 + SETTLE) @(negedge clk);
        checkOutput("t1_pos5_not_yet", 32'(pos5), 32'd0);
        @(negedge clk);
        checkOutput("t1_pos5", 32'(pos5), 32'd2);
        checkOutput("t1_last", 32'(last_comp_pos), 32'd5);
        checkOutput("t1_model_pos5", 32'(mb[5]), 32'd2);
        @(negedge clk);
        checkOutput("t1_turn_back", 32'(player_turn), 32'd1);

        // Checker block suggestion followed.
        applyStimulus(4'd2, 1'b1, 4'd3);
        waitIdle();
        checkOutput("t2_pos3", 32'(pos3), 32'd2);
        checkOutput("t2_winner", 32'(winner), 32'd0);
        checkOutput("t2_last", 32'(last_comp_pos), 32'd3);

        // Illegal moves: occupied cell and out-of-range cell.
        applyStimulus(4'd5, 1'b0, 4'd0);
        checkOutput("t3_illegal_occ", 32'(illegal), 32'd1);
        checkOutput("t3_board", 32'(dut_board), 32'(boardLit(9'b000000011, 9'b000010100)));
        @(negedge clk);
        checkOutput("t3_illegal_pulse_end", 32'(illegal), 32'd0);
        applyStimulus(4'd12, 1'b0, 4'd0);
        checkOutput("t3_illegal_range", 32'(illegal), 32'd1);
        checkOutput("t3_board2", 32'(dut_board), 32'(boardLit(9'b000000011, 9'b000010100)));

        // Player wins on the 3-5-7 diagonal.
        restartPulse();
        checkOutput("t4_restart_board", 32'(dut_board), 32'd0);
        applyStimulus(4'd5, 1'b1, 4'd1);
        waitIdle();
        applyStimulus(4'd3, 1'b1, 4'd2);
        waitIdle();
        applyStimulus(4'd7, 1'b0, 4'd0);
        @(negedge clk);
        checkOutput("t4_winner", 32'(winner), 32'd1);
        checkOutput("t4_game_over", 32'(game_over), 32'd1);
        repeat (SETTLE + 3) @(negedge clk);
        checkOutput("t4_no_comp_move", 32'(dut_board), 32'(boardLit(9'b001010100, 9'b000000011)));
        checkOutput("t4_last", 32'(last_comp_pos), 32'd2);
        applyStimulus(4'd9, 1'b0, 4'd0);
        checkOutput("t4_done_no_illegal", 32'(illegal), 32'd0);
        checkOutput("t4_done_board", 32'(dut_board), 32'(boardLit(9'b001010100, 9'b000000011)));
        restartPulse();
        checkOutput("t4_clear_board", 32'(dut_board), 32'd0);
        checkOutput("t4_clear_turn", 32'(player_turn), 32'd1);
        checkOutput("t4_clear_winner", 32'(winner), 32'd0);
        checkOutput("t4_clear_over", 32'(game_over), 32'd0);

        // Draw: player fills the last cell.
        applyStimulus(4'd1, 1'b1, 4'd5);
        waitIdle();
        applyStimulus(4'd3, 1'b1, 4'd2);
        waitIdle();
        applyStimulus(4'd4, 1'b1, 4'd7);
        waitIdle();
        applyStimulus(4'd8, 1'b1, 4'd6);
        waitIdle();
        applyStimulus(4'd9, 1'b0, 4'd0);
        @(negedge clk);
        checkOutput("t5_winner_draw", 32'(winner), 32'd3);
        checkOutput("t5_board", 32'(dut_board), 32'(boardLit(9'b110001101, 9'b001110010)));

        // Reset while waiting for the computer discards its move.
        restartPulse();
        applyStimulus(4'd1, 1'b0, 4'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_reset_board", 32'(dut_board), 32'd0);
        checkOutput("t6_reset_turn", 32'(player_turn), 32'd1);
        #1 reset = 1'b0;
        repeat (SETTLE + 4) @(negedge clk);
        checkOutput("t6_still_empty", 32'(dut_board), 32'd0);
`else
        repeat (2) @(negedge clk);
        checkOutput("cf_pos5", 32'(pos5), 32'd2);
        checkOutput("cf_last", 32'(last_comp_pos), 32'd5);
        checkOutput("cf_turn", 32'(player_turn), 32'd1);
        applyStimulus(4'd1, 1'b0, 4'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("cf_reset_board", 32'(dut_board), 32'd0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("cf_reset_pos5", 32'(pos5), 32'd2);
`endif

        // Random play; the compare process checks every cycle.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            #1;
            player_move = ($urandom_range(0, 1) == 1);
            player_pos  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 9));
            check       = ($urandom_range(0, 1) == 1);
            blockthis   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 9));
            restart     = m_over ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 80) == 0);
            reset       = ($urandom_range(0, 400) == 0);
        end
        @(negedge clk);
        #1;
        player_move = 1'b0; restart = 1'b0; reset = 1'b0; check = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
